// File: rtl/unix_to_datetime_if.sv
// unix_to_datetime_if: start/busy/done bundle between the
// seconds counter, the converter and the display stage.
interface unix_to_datetime_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] unix_time;
  logic         busy;
  logic         done;
  logic         err;
  logic [11:0]  year;
  logic [3:0]   month;
  logic [4:0]   day;
  logic [4:0]   hour;
  logic [5:0]   minute;
  logic [5:0]   second;
  logic [2:0]   weekday;

  modport master (
    output start, unix_time,
    input  busy, done, err,
    input  year, month, day,
    input  hour, minute, second,
    input  weekday
  );

  modport slave (
    input  start, unix_time,
    output busy, done, err,
    output year, month, day,
    output hour, minute, second,
    output weekday
  );
endinterface

// File: rtl/unix_to_datetime.sv
// unix_to_datetime: iterative Unix-seconds to UTC calendar
// converter; shift-subtract only, no hardware divider.
module unix_to_datetime #(
  parameter int N = 64
) (
  input logic              clk,
  input logic              reset_n,
  unix_to_datetime_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_DIV,
    S_HOUR,
    S_MIN,
    S_YEAR,
    S_MONTH
  } state_t;

  state_t state_q, state_d;

  logic [31:0] val_q, val_d;
  logic [16:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  h_q, h_d;
  logic [5:0]  m_q, m_d;
  logic [11:0] y_q, y_d;
  logic [3:0]  mo_q, mo_d;
  logic [2:0]  wd_q, wd_d;

  logic [11:0] year_q, year_d;
  logic [3:0]  month_q, month_d;
  logic [4:0]  day_q, day_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  minute_q, minute_d;
  logic [5:0]  second_q, second_d;
  logic [2:0]  weekday_q, weekday_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        hi_nz;
  logic        accept;
  logic [17:0] trial;
  logic        div_ge;
  logic [16:0] trial_sub;
  logic [16:0] days;
  logic        leap;
  logic [16:0] ylen;
  logic        ge_y;
  logic [4:0]  mlen;
  logic        ge_mo;
  logic [1:0]  mlen_m7;
  logic        ge_hr;
  logic        ge_mn;

  function automatic logic [2:0] mod7(
    input logic [5:0] v
  );
    logic [5:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r >= 6'd7) r = r - 6'd7;
    end
    return r[2:0];
  endfunction

  // Out-of-range detect on the upper input bits
  if (N > 32) begin : g_hi
    assign hi_nz = |bus.unix_time[N-1:32];
  end else begin : g_nohi
    assign hi_nz = 1'b0;
  end

  // Shared compares and calendar lookups
  always_comb begin
    accept    = bus.start && !done_q;
    trial     = {rem_q, val_q[31]};
    div_ge    = trial >= 18'd86400;
    trial_sub = 17'(trial - 18'd86400);
    days      = val_q[16:0];
    leap      = (y_q[1:0] == 2'd0) &&
                (y_q != 12'd2100);
    ylen      = leap ? 17'd366 : 17'd365;
    ge_y      = days >= ylen;
    unique case (mo_q)
      4'd2:    mlen = leap ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   mlen = 5'd30;
      default: mlen = 5'd31;
    endcase
    // 28..31 mod 7 is simply mlen-28
    mlen_m7   = 2'(mlen - 5'd28);
    ge_mo     = days >= {12'd0, mlen};
    ge_hr     = rem_q >= 17'd3600;
    ge_mn     = rem_q >= 17'd60;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = hi_nz ? S_ERR : S_DIV;
      S_ERR:
        state_d = S_IDLE;
      S_DIV:
        if (cnt_q == 5'd31)
          state_d = S_HOUR;
      S_HOUR:
        if (!ge_hr) state_d = S_MIN;
      S_MIN:
        if (!ge_mn) state_d = S_YEAR;
      S_YEAR:
        if (!ge_y) state_d = S_MONTH;
      S_MONTH:
        if (!ge_mo) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Datapath and result registers next values
  always_comb begin
    val_d     = val_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    m_d       = m_q;
    y_d       = y_q;
    mo_d      = mo_q;
    wd_d      = wd_q;
    year_d    = year_q;
    month_d   = month_q;
    day_d     = day_q;
    hour_d    = hour_q;
    minute_d  = minute_q;
    second_d  = second_q;
    weekday_d = weekday_q;
    err_d     = err_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          val_d = bus.unix_time[31:0];
          rem_d = '0;
          cnt_d = '0;
          h_d   = '0;
          m_d   = '0;
          y_d   = 12'd1970;
          mo_d  = 4'd1;
          wd_d  = 3'd4;
        end
      end
      S_ERR: begin
        err_d  = 1'b1;
        done_d = 1'b1;
      end
      S_DIV: begin
        rem_d = div_ge ? trial_sub
                       : trial[16:0];
        val_d = {val_q[30:0], div_ge};
        cnt_d = cnt_q + 5'd1;
      end
      S_HOUR: begin
        if (ge_hr) begin
          rem_d = rem_q - 17'd3600;
          h_d   = h_q + 5'd1;
        end
      end
      S_MIN: begin
        if (ge_mn) begin
          rem_d = rem_q - 17'd60;
          m_d   = m_q + 6'd1;
        end
      end
      S_YEAR: begin
        if (ge_y) begin
          val_d = {15'd0, days - ylen};
          y_d   = y_q + 12'd1;
          wd_d  = mod7({3'd0, wd_q} +
                  (leap ? 6'd2 : 6'd1));
        end
      end
      S_MONTH: begin
        if (ge_mo) begin
          val_d = {15'd0,
                   days - {12'd0, mlen}};
          mo_d  = mo_q + 4'd1;
          wd_d  = mod7({3'd0, wd_q} +
                       {4'd0, mlen_m7});
        end else begin
          year_d    = y_q;
          month_d   = mo_q;
          day_d     = days[4:0] + 5'd1;
          hour_d    = h_q;
          minute_d  = m_q;
          second_d  = rem_q[5:0];
          weekday_d = mod7({3'd0, wd_q} +
                           {1'b0, days[4:0]});
          err_d     = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      h_q       <= '0;
      m_q       <= '0;
      y_q       <= 12'd1970;
      mo_q      <= 4'd1;
      wd_q      <= 3'd4;
      year_q    <= 12'd1970;
      month_q   <= 4'd1;
      day_q     <= 5'd1;
      hour_q    <= '0;
      minute_q  <= '0;
      second_q  <= '0;
      weekday_q <= 3'd4;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      val_q     <= val_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      h_q       <= h_d;
      m_q       <= m_d;
      y_q       <= y_d;
      mo_q      <= mo_d;
      wd_q      <= wd_d;
      year_q    <= year_d;
      month_q   <= month_d;
      day_q     <= day_d;
      hour_q    <= hour_d;
      minute_q  <= minute_d;
      second_q  <= second_d;
      weekday_q <= weekday_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Outputs
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.year    = year_q;
  assign bus.month   = month_q;
  assign bus.day     = day_q;
  assign bus.hour    = hour_q;
  assign bus.minute  = minute_q;
  assign bus.second  = second_q;
  assign bus.weekday = weekday_q;

endmodule
